// File: rtl/rotate_seq_ctrl.sv
// Command sequencer for a universal rotate register: loads a word, issues the
// requested rotate steps, captures q and flags any mismatch against the expected rotation.
module rotate_seq_ctrl #(
    parameter int unsigned DW = 4,
    parameter int unsigned AW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          async_rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [DW-1:0] cmd_data,
    input  logic          cmd_dir,
    input  logic [AW-1:0] cmd_amt,
    output logic [1:0]    rot_ctrl,
    output logic [DW-1:0] rot_data,
    input  logic [DW-1:0] rot_q,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          res_err,
    output logic          busy
);

    typedef enum logic [2:0] {StIdle, StLoad, StShift, StCapture, StDone} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic          dir_q, dir_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] exp_q, exp_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic          res_err_q, res_err_d;
    logic          res_valid_q, res_valid_d;

    function automatic logic [DW-1:0] rot_left(input logic [DW-1:0] x, input logic [AW-1:0] n);
        logic [2*DW-1:0] t;
        t = {x, x} << n;
        return t[2*DW-1 -: DW];
    endfunction

    function automatic logic [DW-1:0] rot_right(input logic [DW-1:0] x, input logic [AW-1:0] n);
        logic [2*DW-1:0] t;
        t = {x, x} >> n;
        return t[DW-1:0];
    endfunction

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q     <= StIdle;
            data_q      <= '0;
            dir_q       <= 1'b0;
            cnt_q       <= '0;
            exp_q       <= '0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        dir_d       = dir_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        res_valid_d = res_valid_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    data_d  = cmd_data;
                    dir_d   = cmd_dir;
                    cnt_d   = cmd_amt;
                    exp_d   = cmd_dir ? rot_right(cmd_data, cmd_amt) : rot_left(cmd_data, cmd_amt);
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = (cnt_q != '0) ? StShift : StCapture;
            end
            StShift: begin
                cnt_d = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                res_data_d  = rot_q;
                res_err_d   = (rot_q != exp_q);
                res_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs depend on registered state only.
    always_comb begin
        rot_ctrl = 2'b11;
        unique case (state_q)
            StLoad:  rot_ctrl = 2'b00;
            StShift: rot_ctrl = dir_q ? 2'b01 : 2'b10;
            default: rot_ctrl = 2'b11;
        endcase
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rot_data  = data_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

endmodule

// File: doc/rotate_seq_ctrl.md
Name: rotate_seq_ctrl

Overview:
Command sequencer placed directly upstream of the universal rotate register (async-reset, 2-bit ctrl: 00 load, 10 rotate-left, 01 rotate-right, 11 hold). It accepts a {data, direction, amount} command over a valid/ready handshake and drives the register's ctrl/data for the required number of cycles. It then reads back the register output q and returns the rotated word with a self-check flag over a second valid/ready handshake.

Parameters:
DW, 4, data width of the rotate register; power of two, >= 2
AW, $clog2(DW), width of the rotate amount (derived; not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
async_rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at rising edge
cmd_data  input  DW  word to load
cmd_dir  input  1  0 = rotate left, 1 = rotate right
cmd_amt  input  AW  rotate positions, 0..DW-1
rot_ctrl  output  2  ctrl to the rotate register
rot_data  output  DW  data to the rotate register
rot_q  input  DW  rotate register output q
res_valid  output  1  result available
res_ready  input  1  result consumed when res_valid && res_ready at rising edge
res_data  output  DW  captured rot_q
res_err  output  1  1 when captured rot_q differs from internally computed expected rotation
busy  output  1  state != IDLE

Behaviour:
- Reset (async_rst_n=0, takes effect immediately, no clock needed): state=IDLE, rot_ctrl=11, rot_data=0, res_data=0, res_err=0, res_valid=0, cmd_ready=1, busy=0, internal counters/latches=0.
- States: IDLE, LOAD, SHIFT, CAPTURE, DONE.
- IDLE: cmd_ready=1, rot_ctrl=11. On accept: latch cmd_data/dir/amt, compute expected = cmd_data rotated by amt in dir; go to LOAD. cmd_ready is 0 in every other state; cmd_valid outside IDLE is ignored.
- LOAD (1 cycle): rot_ctrl=00, rot_data=latched data. Next: SHIFT with counter=amt if amt!=0, else CAPTURE.
- SHIFT (exactly amt cycles): rot_ctrl=10 (dir=0) or 01 (dir=1); counter decrements each edge; leave to CAPTURE when counter reaches 1 at the edge.
- CAPTURE (1 cycle): rot_ctrl=11; at the edge res_data<=rot_q, res_err<=(rot_q!=expected), res_valid<=1; go to DONE.
- DONE: rot_ctrl=11; res_valid, res_data, res_err held stable while res_ready=0. On res_valid && res_ready: res_valid<=0, go to IDLE. cmd_ready rises the cycle after; no same-cycle result-pop/command-accept.
- rot_data holds the last loaded word outside LOAD (value is don't-care to the register when ctrl!=00, but must not change).
- rot_ctrl and busy are decoded from registered state only (no combinational path from cmd_* or res_ready).
- Latency: accept at edge k -> res_valid high after edge k+amt+2.
- Rotation convention: left = {q[DW-2:0], q[DW-1]}; right = {q[0], q[DW-1:1]}. cmd_amt is AW bits wide, so values wrap modulo DW by width; no range error.
- Reset mid-operation (any state): immediate return to reset values; partially issued command is dropped, no result produced.

Test Plan:
- Reset: assert async_rst_n=0 mid-cycle during SHIFT -> same instant rot_ctrl=11, res_valid=0, cmd_ready=1, busy=0; no res_valid after release.
- Left: cmd_data=4'b1001, dir=0, amt=1, with model register on rot_* -> rot_ctrl sequence 00,10,11; res_data=4'b0011, res_err=0, res_valid 3 edges after accept.
- Right: cmd_data=4'b1000, dir=1, amt=3 -> rot_ctrl 00,01,01,01,11; res_data=4'b0001, res_err=0, latency 5.
- Zero amount: cmd_data=4'b0110, amt=0 -> rot_ctrl 00,11; res_data=4'b0110, latency 2.
- Backpressure: res_ready=0 for 5 cycles with cmd_valid=1 held -> res_valid/res_data stable, rot_ctrl=11, cmd_ready=0, second command not accepted until the cycle after res_ready=1 handshake.
- Self-check: model register forced to skip one shift (data=4'b0001, left, amt=2, q returns 4'b0010) -> res_data=4'b0010, res_err=1; next correct command returns res_err=0.
